adc_acq_capture: RTL and testbench
==================================

Name: adc_acq_capture

Overview:
- Acquisition-side responder to the system sequencer's `start_sampling` strobe.
- On each accepted strobe, writes exactly P_SAMPLES consecutive ADC words, one per clk, into the sample RAM through a simple write port.
- Then raises `end_working`, which the sequencer edge-detects, and holds it until the next acquisition is accepted.
- Sits between the ADC input register and the sample RAM that the FFT path later reads.

Parameters:
- P_SAMPLES, 8192, samples captured per acquisition (power of two, ≥4).
- ADDR_W, 13, RAM address width; must satisfy 2**ADDR_W ≥ P_SAMPLES.
- DATA_W, 10, ADC word width.
- P_TWOS, 1, 1 = convert offset-binary ADC code to two's complement (invert MSB); 0 = pass raw code.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start_sampling  in  1  single-cycle start strobe from sequencer.
- abort  in  1  synchronous abort; returns to IDLE, no end_working.
- adc_data  in  DATA_W  ADC sample, valid every clk.
- test_mode  in  1  select test ramp (used only when ADC_ACQ_TEST_PATTERN_EN is defined).
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- busy  out  1  high while capturing.
- end_working  out  1  capture complete; level, held.
- overrun  out  1  sticky: start_sampling seen while busy.
- sample_cnt  out  ADDR_W+1  samples written in current/last acquisition.

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, all outputs 0, adc input register 0. Reset has priority over all other inputs, including mid-capture.
- Input stage: adc_q <= adc_data every cycle, optionally MSB-inverted per P_TWOS. wr_data <= adc_q. The sample written at a given edge is therefore the adc_data presented two edges earlier.
- States: IDLE, CAPTURE, DONE.
- IDLE: wr_en=0, busy=0.
  - start_sampling=1 → CAPTURE, busy<=1, end_working<=0, sample_cnt<=0, internal addr<=0.
- CAPTURE: each cycle wr_en<=1, wr_addr<=addr, addr<=addr+1, sample_cnt<=sample_cnt+1.
  - When addr==P_SAMPLES-1, the write is issued and state→DONE.
  - Timing: strobe at cycle 0 gives writes on cycles 1..P_SAMPLES (addresses 0..P_SAMPLES-1). On cycle P_SAMPLES+1: wr_en=0, busy=0, end_working=1. This fits within the sequencer's P_SAMPLES+3 window.
- DONE: end_working held 1.
  - start_sampling=1 → same action as from IDLE; end_working drops the cycle CAPTURE begins.
  - Otherwise stays in DONE.
- abort=1 in any state → IDLE next cycle. wr_en<=0, busy<=0, end_working<=0; sample_cnt retains its value. abort has priority over start_sampling in the same cycle.
- start_sampling while in CAPTURE: ignored (count and address continue undisturbed), overrun<=1. overrun clears only on reset or on an accepted start.
- Address never wraps within an acquisition. sample_cnt saturates at P_SAMPLES.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: ADC_ACQ_TEST_PATTERN_EN.
- Defined: when test_mode=1 at the accepting start, the whole acquisition writes wr_data = addr[DATA_W-1:0] (ramp 0,1,2,…, aligned with wr_addr, no P_TWOS conversion). test_mode is latched at start; changes mid-capture are ignored.
- Undefined: test_mode is unused; data always comes from adc_data.

Test Plan:
- Reset with reset=0 for 3 cycles, then release → all outputs 0; state IDLE; wr_en never asserts without a start.
- P_SAMPLES=16, adc_data=cycle index, start at cycle 10 → wr_en high on cycles 11–26, wr_addr 0..15, wr_data on cycle 11 = 9 (raw with P_TWOS=0); end_working=1 and busy=0 from cycle 27.
- P_TWOS=1, adc_data=10'h200 constant → every wr_data=10'h000; adc_data=10'h1FF → wr_data=10'h3FF.
- Second start_sampling 5 cycles into capture → overrun=1, still exactly 16 writes, addresses unchanged. Next accepted start clears overrun and drops end_working.
- abort at the 8th write cycle → wr_en=0 next cycle, end_working stays 0, sample_cnt=8. abort and start together in IDLE → stays IDLE.
- With ADC_ACQ_TEST_PATTERN_EN, test_mode=1 at start, then toggled mid-capture → wr_data==wr_addr for all 16 writes.

Source files
------------

// File: rtl/adc_acq_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : adc_acq_capture
// Purpose : On each accepted start strobe, writes P_SAMPLES consecutive ADC
//           words into the sample RAM, then holds end_working until the next
//           acquisition. Optional ramp source: define ADC_ACQ_TEST_PATTERN_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module adc_acq_capture #(
  parameter int P_SAMPLES = 8192,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 10,
  parameter int P_TWOS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_sampling,
  input  logic              abort,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              test_mode,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              end_working,
  output logic              overrun,
  output logic [ADDR_W:0]   sample_cnt
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(P_SAMPLES - 1);
  localparam logic [ADDR_W:0]   c_max_cnt   = (ADDR_W+1)'(P_SAMPLES);
  localparam logic [DATA_W-1:0] c_msb_flip  = (P_TWOS != 0) ? {1'b1, {(DATA_W-1){1'b0}}}
                                                            : {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_adc_q;
  logic                w_accept;
  logic                w_wr_en_nxt, w_busy_nxt, w_end_nxt, w_ovr_nxt;
  logic [ADDR_W-1:0]   w_wr_addr_nxt;
  logic [DATA_W-1:0]   w_wr_data_nxt;
  logic [ADDR_W:0]     w_cnt_nxt;

`ifdef ADC_ACQ_TEST_PATTERN_EN
  logic                r_tm, w_tm_nxt;
`else
  logic                w_unused;
  assign w_unused = test_mode;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_adc_q     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      end_working <= 1'b0;
      overrun     <= 1'b0;
      sample_cnt  <= '0;
`ifdef ADC_ACQ_TEST_PATTERN_EN
      r_tm        <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_adc_q     <= adc_data ^ c_msb_flip;
      wr_en       <= w_wr_en_nxt;
      wr_addr     <= w_wr_addr_nxt;
      wr_data     <= w_wr_data_nxt;
      busy        <= w_busy_nxt;
      end_working <= w_end_nxt;
      overrun     <= w_ovr_nxt;
      sample_cnt  <= w_cnt_nxt;
`ifdef ADC_ACQ_TEST_PATTERN_EN
      r_tm        <= w_tm_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_accept      = 1'b0;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = wr_addr;
    w_busy_nxt    = busy;
    w_end_nxt     = end_working;
    w_ovr_nxt     = overrun;
    w_cnt_nxt     = sample_cnt;
`ifdef ADC_ACQ_TEST_PATTERN_EN
    w_tm_nxt      = r_tm;
`endif

    // abort wins over everything, including a coincident start strobe
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_busy_nxt  = 1'b0;
      w_end_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_busy_nxt = 1'b0;
          w_accept   = start_sampling;
        end
        ST_CAPTURE: begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_addr;
          w_addr_nxt    = r_addr + ADDR_W'(1);
          if (sample_cnt != c_max_cnt) begin
            w_cnt_nxt = sample_cnt + (ADDR_W+1)'(1);
          end
          if (start_sampling) begin
            w_ovr_nxt = 1'b1;
          end
          if (r_addr == c_last_addr) begin
            w_state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          w_busy_nxt = 1'b0;
          w_end_nxt  = 1'b1;
          w_accept   = start_sampling;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end

    if (w_accept) begin
      w_state_nxt = ST_CAPTURE;
      w_addr_nxt  = '0;
      w_busy_nxt  = 1'b1;
      w_end_nxt   = 1'b0;
      w_ovr_nxt   = 1'b0;
      w_cnt_nxt   = '0;
`ifdef ADC_ACQ_TEST_PATTERN_EN
      w_tm_nxt    = test_mode;
`endif
    end

    w_wr_data_nxt = r_adc_q;
`ifdef ADC_ACQ_TEST_PATTERN_EN
    // ramp tracks the address of the write being issued this cycle
    if (w_wr_en_nxt && r_tm) begin
      w_wr_data_nxt = DATA_W'(r_addr);
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_acq_capture.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for adc_acq_capture: two instances (raw and two's
// complement output) checked against a phase-based acquisition model.
module tb_adc_acq_capture;

  localparam int P  = 16;
  localparam int AW = 4;
  localparam int DW = 10;
  localparam int CW = AW + AW + 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_sampling = 1'b0;
  logic abort = 1'b0;
  logic test_mode = 1'b0;
  logic [DW-1:0] adc_data = '0;

  logic          wr_en0, busy0, end_working0, overrun0;
  logic [AW-1:0] wr_addr0;
  logic [DW-1:0] wr_data0;
  logic [AW:0]   cnt0;
  logic          wr_en1, busy1, end_working1, overrun1;
  logic [AW-1:0] wr_addr1;
  logic [DW-1:0] wr_data1;
  logic [AW:0]   cnt1;

  wire [CW-1:0] ctrl0 = {wr_en0, wr_addr0, busy0, end_working0, overrun0, cnt0};
  wire [CW-1:0] ctrl1 = {wr_en1, wr_addr1, busy1, end_working1, overrun1, cnt1};

  int n_chk = 0;
  int n_fail = 0;

  adc_acq_capture #(.P_SAMPLES(P), .ADDR_W(AW), .DATA_W(DW), .P_TWOS(0)) dut0 (
    .clk(clk), .reset(reset), .start_sampling(start_sampling), .abort(abort),
    .adc_data(adc_data), .test_mode(test_mode), .wr_en(wr_en0), .wr_addr(wr_addr0),
    .wr_data(wr_data0), .busy(busy0), .end_working(end_working0), .overrun(overrun0),
    .sample_cnt(cnt0));

  adc_acq_capture #(.P_SAMPLES(P), .ADDR_W(AW), .DATA_W(DW), .P_TWOS(1)) dut1 (
    .clk(clk), .reset(reset), .start_sampling(start_sampling), .abort(abort),
    .adc_data(adc_data), .test_mode(test_mode), .wr_en(wr_en1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .busy(busy1), .end_working(end_working1), .overrun(overrun1),
    .sample_cnt(cnt1));

  always #5 clk = ~clk;

  // Reference model: ph = edges since the accepting start (-1 = no acquisition).
  // Writes occur at phases 1..P with address ph-1; end_working from phase P+1.
  int            ph = -1;
  logic          m_en = 0, m_busy = 0, m_ew = 0, m_ov = 0, m_tm = 0;
  logic [AW-1:0] m_addr = '0;
  logic [AW:0]   m_cnt = '0;
  logic [DW-1:0] m_q0 = '0, m_q1 = '0, m_d0 = '0, m_d1 = '0;

  always @(posedge clk) begin
    if (!reset) begin
      ph = -1; m_en = 0; m_busy = 0; m_ew = 0; m_ov = 0; m_tm = 0;
      m_addr = '0; m_cnt = '0; m_q0 = '0; m_q1 = '0; m_d0 = '0; m_d1 = '0;
    end else begin
      m_en = 0;
      if (abort) begin
        ph = -1; m_busy = 0; m_ew = 0;
      end else if (ph >= 0 && ph < P) begin
        if (start_sampling) m_ov = 1;
        ph = ph + 1;
        m_en = 1; m_addr = AW'(ph - 1); m_cnt = (AW+1)'(ph); m_busy = 1;
      end else if (start_sampling) begin
        ph = 0; m_cnt = '0; m_ov = 0; m_busy = 1; m_ew = 0;
`ifdef ADC_ACQ_TEST_PATTERN_EN
        m_tm = test_mode;
`endif
      end else begin
        m_busy = 0;
        if (ph >= P) begin ph = P + 1; m_ew = 1; end
      end
      m_d0 = (m_en && m_tm) ? DW'(m_addr) : m_q0;
      m_d1 = (m_en && m_tm) ? DW'(m_addr) : m_q1;
      m_q0 = adc_data;
      m_q1 = adc_data ^ 10'h200;
    end
  end

  function automatic logic [CW-1:0] exp_ctrl();
    return {m_en, m_addr, m_busy, m_ew, m_ov, m_cnt};
  endfunction

  task automatic step(input logic s, input logic a, input logic [DW-1:0] d);
    @(negedge clk);
    start_sampling = s;
    abort = a;
    adc_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      step(1'b1, 1'b0, DW'($urandom));
      n_chk++;
      if ({ctrl0, wr_data0, ctrl1, wr_data1} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs act=%h/%h req=0", ctrl0, ctrl1);
      end
    end
    reset = 1'b1;
    repeat (6) begin
      step(1'b0, 1'b0, DW'($urandom));
      n_chk++;
      if (wr_en0 !== 1'b0 || busy0 !== 1'b0 || ctrl0 !== exp_ctrl() || wr_data0 !== m_d0) begin
        n_fail++;
        $display("FAIL reset_idle act=%h/%h req=%h/%h", ctrl0, wr_data0, exp_ctrl(), m_d0);
      end
    end
  endtask

  task automatic test_capture();
    for (int c = 1; c <= 34; c++) begin
      logic exp_en;
      step(c == 10, 1'b0, DW'(c - 1));
      exp_en = (c >= 11 && c <= 26);
      n_chk++;
      if (ctrl0 !== exp_ctrl() || wr_data0 !== m_d0) begin
        n_fail++;
        $display("FAIL cap_model0 c=%0d act=%h/%h req=%h/%h", c, ctrl0, wr_data0, exp_ctrl(), m_d0);
      end
      n_chk++;
      if (ctrl1 !== exp_ctrl() || wr_data1 !== m_d1) begin
        n_fail++;
        $display("FAIL cap_model1 c=%0d act=%h/%h req=%h/%h", c, ctrl1, wr_data1, exp_ctrl(), m_d1);
      end
      n_chk++;
      if (wr_en0 !== exp_en) begin
        n_fail++;
        $display("FAIL cap_wr_en c=%0d act=%b req=%b", c, wr_en0, exp_en);
      end
      if (exp_en) begin
        n_chk++;
        if (wr_addr0 !== AW'(c - 11) || wr_data0 !== DW'(c - 2)) begin
          n_fail++;
          $display("FAIL cap_write c=%0d act=%0d/%0d req=%0d/%0d", c, wr_addr0, wr_data0, c - 11, c - 2);
        end
      end
      if (c >= 27) begin
        n_chk++;
        if (end_working0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 5'd16) begin
          n_fail++;
          $display("FAIL cap_done c=%0d act=%b/%b/%0d req=1/0/16", c, end_working0, busy0, cnt0);
        end
      end
    end
  endtask

  task automatic test_twos();
    repeat (3) step(1'b0, 1'b0, 10'h200);
    n_chk++;
    if (wr_data1 !== 10'h000 || wr_data0 !== 10'h200) begin
      n_fail++;
      $display("FAIL twos_200 act=%h/%h req=000/200", wr_data1, wr_data0);
    end
    repeat (3) step(1'b0, 1'b0, 10'h1FF);
    n_chk++;
    if (wr_data1 !== 10'h3FF || wr_data0 !== 10'h1FF) begin
      n_fail++;
      $display("FAIL twos_1ff act=%h/%h req=3ff/1ff", wr_data1, wr_data0);
    end
  endtask

  task automatic test_overrun();
    int k = 0;
    step(1'b1, 1'b0, DW'($urandom));
    for (int c = 1; c <= 22; c++) begin
      step(c == 6, 1'b0, DW'($urandom));
      n_chk++;
      if (ctrl0 !== exp_ctrl() || ctrl1 !== exp_ctrl()) begin
        n_fail++;
        $display("FAIL ovr_model c=%0d act=%h/%h req=%h", c, ctrl0, ctrl1, exp_ctrl());
      end
      if (wr_en0) begin
        n_chk++;
        if (wr_addr0 !== AW'(k)) begin
          n_fail++;
          $display("FAIL ovr_addr act=%0d req=%0d", wr_addr0, k);
        end
        k++;
      end
    end
    n_chk++;
    if (k != P) begin
      n_fail++;
      $display("FAIL ovr_writes act=%0d req=%0d", k, P);
    end
    n_chk++;
    if (overrun0 !== 1'b1 || end_working0 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_flag act=%b/%b req=1/1", overrun0, end_working0);
    end
    step(1'b1, 1'b0, DW'($urandom));
    n_chk++;
    if (overrun0 !== 1'b0 || end_working0 !== 1'b0 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_restart act=%b/%b/%b req=0/0/1", overrun0, end_working0, busy0);
    end
    repeat (20) step(1'b0, 1'b0, DW'($urandom));
  endtask

  task automatic test_abort();
    step(1'b1, 1'b0, DW'($urandom));
    repeat (8) step(1'b0, 1'b0, DW'($urandom));
    n_chk++;
    if (wr_en0 !== 1'b1 || cnt0 !== 5'd8) begin
      n_fail++;
      $display("FAIL abort_pre act=%b/%0d req=1/8", wr_en0, cnt0);
    end
    step(1'b0, 1'b1, DW'($urandom));
    n_chk++;
    if (wr_en0 !== 1'b0 || busy0 !== 1'b0 || end_working0 !== 1'b0 || cnt0 !== 5'd8) begin
      n_fail++;
      $display("FAIL abort_stop act=%b/%b/%b/%0d req=0/0/0/8", wr_en0, busy0, end_working0, cnt0);
    end
    repeat (3) begin
      step(1'b0, 1'b0, DW'($urandom));
      n_chk++;
      if (ctrl0 !== exp_ctrl() || end_working0 !== 1'b0 || wr_en0 !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle act=%h req=%h", ctrl0, exp_ctrl());
      end
    end
    step(1'b1, 1'b1, DW'($urandom));
    step(1'b0, 1'b0, DW'($urandom));
    n_chk++;
    if (busy0 !== 1'b0 || wr_en0 !== 1'b0 || end_working0 !== 1'b0 || ctrl1 !== exp_ctrl()) begin
      n_fail++;
      $display("FAIL abort_start act=%b/%b/%b req=0/0/0", busy0, wr_en0, end_working0);
    end
  endtask

`ifdef ADC_ACQ_TEST_PATTERN_EN
  task automatic test_pattern();
    int k = 0;
    step(1'b0, 1'b1, DW'($urandom));
    test_mode = 1'b1;
    step(1'b1, 1'b0, DW'($urandom));
    for (int c = 1; c <= 20; c++) begin
      test_mode = ~test_mode;
      step(1'b0, 1'b0, DW'($urandom));
      if (wr_en0) begin
        n_chk++;
        if (wr_addr0 !== AW'(k) || wr_data0 !== DW'(k) || wr_data1 !== DW'(k)) begin
          n_fail++;
          $display("FAIL pattern act=%0d/%0d/%0d req=%0d", wr_addr0, wr_data0, wr_data1, k);
        end
        k++;
      end
    end
    n_chk++;
    if (k != P) begin
      n_fail++;
      $display("FAIL pattern_writes act=%0d req=%0d", k, P);
    end
    test_mode = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 149) != 0);
      test_mode = 1'($urandom_range(0, 1));
      step($urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0, DW'($urandom));
      n_chk++;
      if (ctrl0 !== exp_ctrl() || wr_data0 !== m_d0) begin
        n_fail++;
        $display("FAIL rand0 i=%0d act=%h/%h req=%h/%h", i, ctrl0, wr_data0, exp_ctrl(), m_d0);
      end
      n_chk++;
      if (ctrl1 !== exp_ctrl() || wr_data1 !== m_d1) begin
        n_fail++;
        $display("FAIL rand1 i=%0d act=%h/%h req=%h/%h", i, ctrl1, wr_data1, exp_ctrl(), m_d1);
      end
    end
    reset = 1'b1;
    test_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_twos();
    test_overrun();
    test_abort();
`ifdef ADC_ACQ_TEST_PATTERN_EN
    test_pattern();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
